inst_data_arbiter: RTL and testbench
====================================

# inst_data_arbiter

Shares the single external memory bus between the openmips instruction-fetch port and the data-access (MEM stage) port. Grants one requester at a time with fixed data-over-fetch priority and drives a registered bus transaction until the slave acknowledges. Returns read data or write completion to the owning port and raises stall requests to the pipeline controller while a port waits. Sits at the top level, between the core's ROM/RAM ports and the shared memory.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte-select width is `DATA_W/8`.
- `TIMEOUT`, 255: bus cycles without `bus_ack_i` before the transaction is aborted; must be 1..255.
- `clk  in  1  single clock; all state changes on its rising edge.`
- `rst  in  1  asynchronous, active-low reset.`
- `if_req_i  in  1  fetch request, held until if_ack_o.` / `if_addr_i  in  ADDR_W` / `if_flush_i  in  1  pipeline flush; discard any pending fetch.`
- `if_data_o  out  DATA_W  fetched word, valid with if_ack_o.` / `if_ack_o  out  1  one-cycle completion pulse.`
- `mem_req_i  in  1` / `mem_we_i  in  1` / `mem_sel_i  in  DATA_W/8` / `mem_addr_i  in  ADDR_W` / `mem_wdata_i  in  DATA_W`.
- `mem_rdata_o  out  DATA_W` / `mem_ack_o  out  1` / `mem_err_o  out  1  timeout flag, valid with mem_ack_o.`
- `bus_ce_o  out  1` / `bus_we_o  out  1` / `bus_sel_o  out  DATA_W/8` / `bus_addr_o  out  ADDR_W` / `bus_wdata_o  out  DATA_W`.
- `bus_rdata_i  in  DATA_W` / `bus_ack_i  in  1  slave completion, sampled only while bus_ce_o=1.`
- `stallreq_if_o  out  1` / `stallreq_mem_o  out  1  stall requests to the pipeline controller.`

## Operation
- FSM states: IDLE, IBUSY, DBUSY, DONE.
- IDLE: if `mem_req_i` -> DBUSY (data wins even if `if_req_i`); else if `if_req_i && !if_flush_i` -> IBUSY. The requester's address, write enable, select and write data are registered onto the `bus_*` outputs, and `bus_ce_o` is set.
- IBUSY/DBUSY: bus outputs are held stable; the timeout counter increments each cycle.
  - On `bus_ack_i`: latch `bus_rdata_i` into the owner's data output, pulse the owner's ack, clear `bus_ce_o` -> DONE.
  - On counter == `TIMEOUT` with no ack: clear `bus_ce_o`, pulse ack.
    - For a data abort, `mem_err_o=1` and `mem_rdata_o=0`.
    - For a fetch abort, `if_data_o=0`, which decodes as a nop.
    - -> DONE.
- DONE: one idle bus cycle (turnaround) -> IDLE. A new grant is evaluated in the following IDLE cycle.
- Flush: `if_flush_i` in IBUSY sets a discard flag. The bus transaction still completes (the slave is never abandoned mid-cycle), but `if_ack_o` is suppressed. Flush has no effect on DBUSY.
- Stalls (combinational):
  - `stallreq_if_o = if_req_i && !if_ack_o && !if_flush_i`.
  - `stallreq_mem_o = mem_req_i && !mem_ack_o`.
- Writes: `mem_rdata_o` is driven to 0 on the write ack.
- Only `bus_sel_o` qualifies bytes; the arbiter does not merge or reorder bytes.

## Timing
- Reset (rst=0, async): state IDLE. All outputs are 0: `bus_ce_o`, `bus_we_o`, `bus_sel_o`, `bus_addr_o`, `bus_wdata_o`, `if_data_o`, `if_ack_o`, `mem_rdata_o`, `mem_ack_o`, `mem_err_o`. The discard flag and counter are cleared. Reset mid-transaction drops `bus_ce_o` immediately; the slave must tolerate this.
- Request in IDLE at cycle N -> `bus_ce_o` high at N+1.
- `bus_ack_i` at cycle M (M >= N+1) -> port ack and data at M+1 -> state DONE at M+1 -> IDLE at M+2.
- A request present at M+2 is granted with `bus_ce_o` high at M+3.
- Minimum read latency is 2 cycles (request to ack). Back-to-back throughput is one transaction per 3 cycles.
- Timeout: ack pulse at N+1+`TIMEOUT`.
- Acks are exactly one cycle. Requesters must drop or change their request in the cycle after the ack; a request still held in IDLE after DONE is treated as a new transaction.
- The counter is 8 bits and resets on every grant; it never wraps, because the state is left at `TIMEOUT`.

## Structure
- Shared definitions header (alongside the existing `InstAddrBus`/`InstBus` macros): arbiter state encodings (IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2, DONE=2'd3), plus `Stop`/`NoStop` values for the stall-request outputs.
- One sub-module is natural: `bus_timeout_cnt`, an 8-bit counter with clear, enable and `hit` output at `TIMEOUT`.
- FSM, output registers and discard flag stay in the top module.
- Instantiated in the top level in place of the direct core-to-ROM connection.

## Test plan
- Single fetch: `if_req_i=1`, `if_addr_i=0x100`, slave acks 1 cycle after ce with `0x34011100` -> `bus_addr_o=0x100`, `if_data_o=0x34011100`, `if_ack_o` pulses one cycle; `stallreq_if_o` is high until the ack cycle.
- Simultaneous requests: fetch 0x104 and data write 0x2000 `sel=4'b0011` `wdata=0xDEADBEEF` in the same cycle. The write is granted first (`bus_we_o=1`, `bus_sel_o=4'b0011`), then the fetch is granted 3 cycles after the write ack.
- Flush during fetch: `if_flush_i` pulsed in IBUSY; the slave acks 3 cycles later -> bus completes, `if_ack_o` stays 0, and the next fetch proceeds normally.
- Timeout: data read 0x3000, slave never acks, `TIMEOUT=4` -> `mem_ack_o=1`, `mem_err_o=1`, `mem_rdata_o=0` at grant+5, with `bus_ce_o` cleared in the same cycle.
- Async reset mid-transaction: `rst=0` asserted between clock edges in DBUSY -> all outputs 0 immediately. After release, state is IDLE and a held `if_req_i` is granted on the next edge.
- Byte-select passthrough: data reads at `sel` 4'b0001, 4'b1000 and 4'b1111 -> each `bus_sel_o` matches `mem_sel_i`, and `mem_rdata_o` equals `bus_rdata_i` unmodified.

Source files
------------

// File: rtl/inst_data_arbiter_pkg.sv
// inst_data_arbiter_pkg: shared arbiter state encoding, stall values and counter width
package inst_data_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    DONE  = 2'd3
  } arb_state_e;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int   CNT_W   = 8;
endpackage

// File: rtl/inst_data_arbiter_timeout_cnt.sv
// bus_timeout_cnt: counts bus cycles of the current transaction and flags the last allowed one
module bus_timeout_cnt
  import inst_data_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [CNT_W-1:0] cnt;
  // cleared on every grant, advances once per busy cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  assign hit = en && (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/inst_data_arbiter.sv
// inst_data_arbiter: shares one memory bus between fetch and data ports, data first
module inst_data_arbiter
  import inst_data_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_ack_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                mem_err_o,
  output logic                bus_ce_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o
);
  arb_state_e state, state_d;
  logic grant_d, grant_i, busy, fin, hit, discard;
  assign busy = (state == IBUSY) || (state == DBUSY);
  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (grant_d || grant_i),
    .en  (busy),
    .hit (hit)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  // grant decision and transaction end; DONE always falls back to IDLE
  always_comb begin
    grant_d = (state == IDLE) && mem_req_i;
    grant_i = (state == IDLE) && !mem_req_i && if_req_i && !if_flush_i;
    fin     = busy && (bus_ack_i || hit);
    state_d = grant_d ? DBUSY :
              grant_i ? IBUSY :
              fin     ? DONE  :
              (state == DONE) ? IDLE : state;
  end
  // bus drive, port responses and fetch discard flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus_ce_o    <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
      mem_err_o   <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      mem_err_o <= 1'b0;
      if (grant_d || grant_i) begin
        bus_ce_o    <= 1'b1;
        bus_we_o    <= grant_d && mem_we_i;
        bus_sel_o   <= grant_d ? mem_sel_i : '1;
        bus_addr_o  <= grant_d ? mem_addr_i : if_addr_i;
        bus_wdata_o <= grant_d ? mem_wdata_i : '0;
        discard     <= 1'b0;
      end
      if (state == IBUSY && if_flush_i) discard <= 1'b1;
      if (fin) begin
        bus_ce_o <= 1'b0;
        if (state == DBUSY) begin
          mem_ack_o   <= 1'b1;
          mem_err_o   <= !bus_ack_i;
          mem_rdata_o <= (bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
        end else if (!(discard || if_flush_i)) begin
          if_ack_o  <= 1'b1;
          if_data_o <= bus_ack_i ? bus_rdata_i : '0;
        end
      end
    end
  assign stallreq_if_o  = (if_req_i && !if_ack_o && !if_flush_i) ? STOP : NO_STOP;
  assign stallreq_mem_o = (mem_req_i && !mem_ack_o) ? STOP : NO_STOP;
endmodule

// File: tb/tb_inst_data_arbiter.sv
// tb_inst_data_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_inst_data_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req_i = 1'b0, if_flush_i = 1'b0, mem_req_i = 1'b0, mem_we_i = 1'b0, bus_ack_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0, mem_addr_i = '0;
  logic [SW-1:0] mem_sel_i = '0;
  logic [DW-1:0] mem_wdata_i = '0, bus_rdata_i = '0;
  logic [DW-1:0] if_data_o, mem_rdata_o, bus_wdata_o;
  logic [AW-1:0] bus_addr_o;
  logic [SW-1:0] bus_sel_o;
  logic if_ack_o, mem_ack_o, mem_err_o, bus_ce_o, bus_we_o, stallreq_if_o, stallreq_mem_o;

  int n_vec = 0, n_err = 0;
  bit run = 1'b1;

  // model: owner 0 none, 1 fetch, 2 data; age = bus cycles spent on the current transaction
  int owner = 0, age = 0;
  bit turn = 1'b0, disc = 1'b0;
  logic e_ce = 0, e_we = 0, e_if_ack = 0, e_mem_ack = 0, e_err = 0;
  logic [SW-1:0] e_sel = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_if_data = '0, e_mem_rdata = '0;

  inst_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_step();
    if (!rst) begin
      owner = 0; age = 0; turn = 0; disc = 0;
      e_ce = 0; e_we = 0; e_sel = '0; e_addr = '0; e_wdata = '0;
      e_if_data = '0; e_if_ack = 0; e_mem_rdata = '0; e_mem_ack = 0; e_err = 0;
    end else begin
      e_if_ack = 0; e_mem_ack = 0; e_err = 0;
      if (turn) turn = 0;
      else if (owner == 0) begin
        if (mem_req_i) begin
          owner = 2; e_we = mem_we_i; e_sel = mem_sel_i; e_addr = mem_addr_i; e_wdata = mem_wdata_i;
        end else if (if_req_i && !if_flush_i) begin
          owner = 1; e_we = 0; e_sel = '1; e_addr = if_addr_i; e_wdata = '0;
        end
        e_ce = (owner != 0); age = 0; disc = 0;
      end else begin
        age++;
        if (owner == 1 && if_flush_i) disc = 1;
        if (bus_ack_i || age == TO) begin
          if (owner == 2) begin
            e_mem_ack = 1; e_err = !bus_ack_i;
            e_mem_rdata = (bus_ack_i && !e_we) ? bus_rdata_i : '0;
          end else if (!disc) begin
            e_if_ack = 1; e_if_data = bus_ack_i ? bus_rdata_i : '0;
          end
          owner = 0; turn = 1; e_ce = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (run) begin
      chk("bus_ce", bus_ce_o, e_ce);
      chk("bus_we", bus_we_o, e_we);
      chk("bus_sel", bus_sel_o, e_sel);
      chk("bus_addr", bus_addr_o, e_addr);
      chk("bus_wdata", bus_wdata_o, e_wdata);
      chk("if_ack", if_ack_o, e_if_ack);
      chk("if_data", if_data_o, e_if_data);
      chk("mem_ack", mem_ack_o, e_mem_ack);
      chk("mem_err", mem_err_o, e_err);
      chk("mem_rdata", mem_rdata_o, e_mem_rdata);
      chk("stall_if", stallreq_if_o, if_req_i && !e_if_ack && !if_flush_i);
      chk("stall_mem", stallreq_mem_o, mem_req_i && !e_mem_ack);
    end
  end

  initial begin
    logic [SW-1:0] sels [3];
    logic [DW-1:0] v;
    sels[0] = 4'b0001; sels[1] = 4'b1000; sels[2] = 4'b1111;
    tick();
    chk("rst_ce", bus_ce_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_if_ack", if_ack_o, 0);
    rst = 1'b1;
    tick();
    // single fetch
    if_req_i = 1; if_addr_i = 32'h100;
    #1 chk("f1_stall", stallreq_if_o, 1);
    tick();
    chk("f1_ce", bus_ce_o, 1);
    chk("f1_addr", bus_addr_o, 32'h100);
    chk("f1_stall_wait", stallreq_if_o, 1);
    bus_ack_i = 1; bus_rdata_i = 32'h34011100;
    tick();
    chk("f1_ack", if_ack_o, 1);
    chk("f1_data", if_data_o, 32'h34011100);
    chk("f1_ce_off", bus_ce_o, 0);
    chk("f1_stall_ack", stallreq_if_o, 0);
    chk("model_if_data", e_if_data, 32'h34011100);
    bus_ack_i = 0; if_req_i = 0;
    tick();
    chk("f1_ack_pulse", if_ack_o, 0);
    // simultaneous fetch and data write: write goes first
    if_req_i = 1; if_addr_i = 32'h104;
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEADBEEF;
    tick();
    chk("s_we", bus_we_o, 1);
    chk("s_sel", bus_sel_o, 4'b0011);
    chk("s_addr", bus_addr_o, 32'h2000);
    chk("s_wdata", bus_wdata_o, 32'hDEADBEEF);
    chk("s_stall_mem", stallreq_mem_o, 1);
    bus_ack_i = 1; bus_rdata_i = 32'h55AA55AA;
    tick();
    chk("s_mem_ack", mem_ack_o, 1);
    chk("s_wr_rdata", mem_rdata_o, 0);
    chk("s_stall_mem_ack", stallreq_mem_o, 0);
    mem_req_i = 0; mem_we_i = 0; bus_ack_i = 0;
    tick();
    chk("s_turn_ce", bus_ce_o, 0);
    tick();
    chk("s_f_ce", bus_ce_o, 1);
    chk("s_f_addr", bus_addr_o, 32'h104);
    bus_ack_i = 1; bus_rdata_i = 32'h00000104;
    tick();
    chk("s_f_ack", if_ack_o, 1);
    if_req_i = 0; bus_ack_i = 0;
    tick();
    // flush during fetch
    if_req_i = 1; if_addr_i = 32'h200;
    tick();
    if_flush_i = 1;
    #1 chk("fl_stall", stallreq_if_o, 0);
    tick();
    if_flush_i = 0; if_addr_i = 32'h300;
    chk("fl_ce_held", bus_ce_o, 1);
    tick();
    bus_ack_i = 1; bus_rdata_i = 32'hBAD0BAD0;
    tick();
    chk("fl_no_ack", if_ack_o, 0);
    chk("fl_ce_off", bus_ce_o, 0);
    chk("fl_addr", bus_addr_o, 32'h200);
    bus_ack_i = 0;
    tick();
    tick();
    chk("fl_next_ce", bus_ce_o, 1);
    chk("fl_next_addr", bus_addr_o, 32'h300);
    bus_ack_i = 1; bus_rdata_i = 32'h11112222;
    tick();
    chk("fl_next_ack", if_ack_o, 1);
    chk("fl_next_data", if_data_o, 32'h11112222);
    if_req_i = 0; bus_ack_i = 0;
    tick();
    // byte-select passthrough, back to back reads
    for (int i = 0; i < 3; i++) begin
      mem_req_i = 1; mem_we_i = 0; mem_sel_i = sels[i]; mem_addr_i = 32'h4000 + 32'(i * 4);
      tick();
      chk("bs_sel", bus_sel_o, sels[i]);
      v = $urandom;
      bus_ack_i = 1; bus_rdata_i = v;
      tick();
      chk("bs_ack", mem_ack_o, 1);
      chk("bs_rdata", mem_rdata_o, v);
      mem_req_i = 0; bus_ack_i = 0;
      tick();
    end
    // timeout on a data read
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h3000;
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("to_wait_ack", mem_ack_o, 0);
      chk("to_wait_ce", bus_ce_o, 1);
    end
    tick();
    chk("to_ack", mem_ack_o, 1);
    chk("to_err", mem_err_o, 1);
    chk("to_rdata", mem_rdata_o, 0);
    chk("to_ce", bus_ce_o, 0);
    chk("model_err", e_err, 1);
    mem_req_i = 0;
    tick();
    tick();
    // asynchronous reset mid-transaction
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0110; mem_addr_i = 32'h5000; mem_wdata_i = 32'hCAFEF00D;
    if_req_i = 1; if_addr_i = 32'h600;
    tick();
    chk("ar_ce", bus_ce_o, 1);
    #2 rst = 0;
    #1;
    chk("ar_ce0", bus_ce_o, 0);
    chk("ar_we0", bus_we_o, 0);
    chk("ar_sel0", bus_sel_o, 0);
    chk("ar_addr0", bus_addr_o, 0);
    chk("ar_wdata0", bus_wdata_o, 0);
    chk("ar_if_data0", if_data_o, 0);
    chk("ar_if_ack0", if_ack_o, 0);
    chk("ar_mem_rdata0", mem_rdata_o, 0);
    chk("ar_mem_ack0", mem_ack_o, 0);
    chk("ar_mem_err0", mem_err_o, 0);
    mem_req_i = 0; mem_we_i = 0;
    tick();
    rst = 1;
    tick();
    chk("ar_grant_ce", bus_ce_o, 1);
    chk("ar_grant_addr", bus_addr_o, 32'h600);
    bus_ack_i = 1; bus_rdata_i = 32'h00000600;
    tick();
    chk("ar_f_ack", if_ack_o, 1);
    if_req_i = 0; bus_ack_i = 0;
    tick();
    tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus_rdata_i = $urandom;
      bus_ack_i = bus_ce_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if_flush_i = ($urandom_range(0, 15) == 0);
      if (if_req_i && if_ack_o) if_req_i = 0;
      else if (if_flush_i && if_req_i) if_addr_i = $urandom & 32'h0000FFFC;
      else if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom & 32'h0000FFFC;
      end
      if (mem_req_i && mem_ack_o) mem_req_i = 0;
      else if (!mem_req_i && $urandom_range(0, 3) == 0) begin
        mem_req_i = 1; mem_we_i = $urandom_range(0, 1) == 1;
        mem_sel_i = SW'($urandom_range(1, 15)); mem_addr_i = $urandom; mem_wdata_i = $urandom;
      end
      if (i % 500 == 250) begin
        rst = 0;
        #2 rst = 1;
      end
    end
    tick();
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
